cv32e40x_div_ctrl: RTL

// - EX-stage issue/response controller and initiator side of the serial divider handshake.
// - Accepts one DIV/DIVU/REM/REMU request from ID via valid/ready and latches operator, operands and the timing mode.
// - Holds divider valid high for the whole operation and buffers the divider result.
// - Presents the result to WB via valid/ready; supports a pipeline kill at any time.

---
 rtl/cv32e40x_pkg.sv | 18 +
 rtl/cv32e40x_div_ctrl_if.sv | 30 +++
 rtl/cv32e40x_div_result_cache.sv | 50 +++++
 rtl/cv32e40x_div_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the EX-stage divider controller: divider opcodes and
// controller FSM states.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    DIV_DIVU = 2'b00,
    DIV_DIV  = 2'b01,
    DIV_REMU = 2'b10,
    DIV_REM  = 2'b11
  } div_opcode_e;

  typedef enum logic [1:0] {
    DIVC_IDLE = 2'b00,
    DIVC_BUSY = 2'b01,
    DIVC_DONE = 2'b10
  } div_ctrl_state_e;

endpackage

// File: rtl/cv32e40x_div_ctrl_if.sv
// Controller <-> serial divider handshake. The master modport is the controller side.
// valid/ready: a transfer happens in a cycle where valid and ready are both high;
// the controller holds div_valid_o for the whole operation and drops it only to kill.
interface cv32e40x_div_ctrl_if;
  import cv32e40x_pkg::*;

  logic        div_en_o;
  logic        div_valid_o;
  logic        div_ready_i;
  logic        div_valid_i;
  logic        div_ready_o;
  div_opcode_e div_operator_o;
  logic [31:0] div_op_a_o;
  logic [31:0] div_op_b_o;
  logic        div_data_ind_timing_o;
  logic [31:0] div_result_i;

  modport master (
    output div_en_o, div_valid_o, div_ready_o, div_operator_o,
           div_op_a_o, div_op_b_o, div_data_ind_timing_o,
    input  div_ready_i, div_valid_i, div_result_i
  );

  modport slave (
    input  div_en_o, div_valid_o, div_ready_o, div_operator_o,
           div_op_a_o, div_op_b_o, div_data_ind_timing_o,
    output div_ready_i, div_valid_i, div_result_i
  );

endinterface

// File: rtl/cv32e40x_div_result_cache.sv
// One-entry cache of the last completed division, compared against the incoming request.
// Only compiled when CV32E40X_DIV_RESULT_CACHE_EN is defined.
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
module cv32e40x_div_result_cache
  import cv32e40x_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  div_opcode_e wr_operator_i,
  input  logic [31:0] wr_op_a_i,
  input  logic [31:0] wr_op_b_i,
  input  logic [31:0] wr_result_i,
  input  div_opcode_e lk_operator_i,
  input  logic [31:0] lk_op_a_i,
  input  logic [31:0] lk_op_b_i,
  input  logic        lk_data_ind_timing_i,
  output logic        hit_o,
  output logic [31:0] hit_result_o
);

  logic        valid_q;
  div_opcode_e operator_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [31:0] result_q;

  // Kill never reaches here; only reset invalidates the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      operator_q <= DIV_DIVU;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
    end else if (wr_en_i) begin
      valid_q    <= 1'b1;
      operator_q <= wr_operator_i;
      op_a_q     <= wr_op_a_i;
      op_b_q     <= wr_op_b_i;
      result_q   <= wr_result_i;
    end
  end

  assign hit_o = valid_q && !lk_data_ind_timing_i && (operator_q == lk_operator_i) &&
                 (op_a_q == lk_op_a_i) && (op_b_q == lk_op_b_i);
  assign hit_result_o = result_q;

endmodule
`endif

// File: rtl/cv32e40x_div_ctrl.sv
// EX-stage issue/response controller for the serial divider.
// Optional result cache: define CV32E40X_DIV_RESULT_CACHE_EN.
module cv32e40x_div_ctrl
  import cv32e40x_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      kill_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  div_opcode_e               req_operator_i,
  input  logic [31:0]               req_op_a_i,
  input  logic [31:0]               req_op_b_i,
  input  logic                      req_data_ind_timing_i,
  cv32e40x_div_ctrl_if.master       div_if,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_result_o,
  output div_ctrl_state_e           state_o
);

  div_ctrl_state_e state_q;
  logic            busy_q;
  logic            done_q;
  div_opcode_e     operator_q;
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic            ind_timing_q;
  logic [31:0]     result_q;
  logic            accept;
  logic            cache_hit;
  logic [31:0]     cache_result;
  logic            unused_div_ready;

  always_comb begin
    req_ready_o = 1'b0;
    if (kill_i) begin
      req_ready_o = 1'b1;
    end else begin
      case (state_q)
        DIVC_IDLE: req_ready_o = 1'b1;
        DIVC_DONE: req_ready_o = rsp_ready_i;
        default:   req_ready_o = 1'b0;
      endcase
    end
  end

  assign accept = req_valid_i && req_ready_o && !kill_i;

`ifdef CV32E40X_DIV_RESULT_CACHE_EN
  cv32e40x_div_result_cache u_cache (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wr_en_i              (busy_q && div_if.div_valid_i && !kill_i),
    .wr_operator_i        (operator_q),
    .wr_op_a_i            (op_a_q),
    .wr_op_b_i            (op_b_q),
    .wr_result_i          (div_if.div_result_i),
    .lk_operator_i        (req_operator_i),
    .lk_op_a_i            (req_op_a_i),
    .lk_op_b_i            (req_op_b_i),
    .lk_data_ind_timing_i (req_data_ind_timing_i),
    .hit_o                (cache_hit),
    .hit_result_o         (cache_result)
  );
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // Flags are registered alongside the state; kill masks them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DIVC_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      operator_q   <= DIV_DIVU;
      op_a_q       <= '0;
      op_b_q       <= '0;
      ind_timing_q <= 1'b0;
      result_q     <= '0;
    end else if (kill_i) begin
      state_q <= DIVC_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIVC_IDLE, DIVC_DONE: begin
          if (accept) begin
            operator_q   <= req_operator_i;
            op_a_q       <= req_op_a_i;
            op_b_q       <= req_op_b_i;
            ind_timing_q <= req_data_ind_timing_i;
            busy_q       <= !cache_hit;
            done_q       <= cache_hit;
            if (cache_hit) begin
              state_q  <= DIVC_DONE;
              result_q <= cache_result;
            end else begin
              state_q  <= DIVC_BUSY;
            end
          end else if (state_q == DIVC_DONE && rsp_ready_i) begin
            state_q <= DIVC_IDLE;
            done_q  <= 1'b0;
          end
        end
        DIVC_BUSY: begin
          if (div_if.div_valid_i) begin
            result_q <= div_if.div_result_i;
            state_q  <= DIVC_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= DIVC_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The divider's input-side ready is not needed: valid is held until the result returns.
  assign unused_div_ready = div_if.div_ready_i;

  assign div_if.div_valid_o           = busy_q && !kill_i;
  assign div_if.div_en_o              = busy_q && !kill_i;
  assign div_if.div_ready_o           = busy_q;
  assign div_if.div_operator_o        = operator_q;
  assign div_if.div_op_a_o            = op_a_q;
  assign div_if.div_op_b_o            = op_b_q;
  assign div_if.div_data_ind_timing_o = ind_timing_q;

  assign rsp_valid_o  = done_q && !kill_i;
  assign rsp_result_o = result_q;
  assign state_o      = state_q;

endmodule
